// File: rtl/etcpu_pkg.sv
// rtl/etcpu_pkg.sv - shared types and default widths for the unified-memory arbiter
package etcpu_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DAT_W  = 32;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } arb_state_e;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch port, data port and memory macro signals of the arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DAT_W  = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_gnt;
    logic              inst_rvalid;
    logic [DAT_W-1:0]  inst_rdata;

    logic              dat_req;
    logic              dat_wen;
    logic [ADDR_W-1:0] dat_addr;
    logic [DAT_W-1:0]  dat_wdata;
    logic              dat_gnt;
    logic              dat_rvalid;
    logic [DAT_W-1:0]  dat_rdata;

    logic              mem_cs;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DAT_W-1:0]  mem_dat_in;
    logic [DAT_W-1:0]  mem_dat_out;

    // Arbiter view.
    modport slave (
        input  inst_req, inst_addr,
        output inst_gnt, inst_rvalid, inst_rdata,
        input  dat_req, dat_wen, dat_addr, dat_wdata,
        output dat_gnt, dat_rvalid, dat_rdata,
        output mem_cs, mem_wen, mem_addr, mem_dat_in,
        input  mem_dat_out
    );

    // Requesters plus memory macro view.
    modport master (
        output inst_req, inst_addr,
        input  inst_gnt, inst_rvalid, inst_rdata,
        output dat_req, dat_wen, dat_addr, dat_wdata,
        input  dat_gnt, dat_rvalid, dat_rdata,
        input  mem_cs, mem_wen, mem_addr, mem_dat_in,
        output mem_dat_out
    );

endinterface

// File: rtl/mem_arb_lat_tracker.sv
// rtl/mem_arb_lat_tracker.sv - tracks the single outstanding read and its return cycle
module mem_arb_lat_tracker
    import etcpu_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_grant,
    input  arb_owner_e grant_owner,
    output logic       free,
    output logic       rvalid_inst,
    output logic       rvalid_data
);

    localparam int LW = $clog2(RD_LAT + 1);

    arb_state_e    state_q, state_d;
    arb_owner_e    owner_q, owner_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic          rvalid_inst_q, rvalid_inst_d;
    logic          rvalid_data_q, rvalid_data_d;

    // The return cycle of a read doubles as an issue slot for the next access.
    assign free        = (state_q == IDLE) || (lat_cnt_q == LW'(1));
    assign rvalid_inst = rvalid_inst_q;
    assign rvalid_data = rvalid_data_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_cnt_d = lat_cnt_q;
        if (rd_grant) begin
            state_d   = RD_WAIT;
            lat_cnt_d = LW'(RD_LAT);
            owner_d   = grant_owner;
        end else if (state_q == RD_WAIT) begin
            if (lat_cnt_q == LW'(1)) begin
                state_d   = IDLE;
                lat_cnt_d = '0;
            end else begin
                lat_cnt_d = lat_cnt_q - LW'(1);
            end
        end
        // rvalid is registered: it is high in the cycle the counter will sit at 1.
        rvalid_inst_d = (state_d == RD_WAIT) && (lat_cnt_d == LW'(1)) && (owner_d == OWN_INST);
        rvalid_data_d = (state_d == RD_WAIT) && (lat_cnt_d == LW'(1)) && (owner_d == OWN_DATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_INST;
            lat_cnt_q     <= '0;
            rvalid_inst_q <= 1'b0;
            rvalid_data_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            lat_cnt_q     <= lat_cnt_d;
            rvalid_inst_q <= rvalid_inst_d;
            rvalid_data_q <= rvalid_data_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between fetch and data ports
module mem_arbiter
    import etcpu_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DAT_W      = DEF_DAT_W,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic              free;
    logic              rvalid_inst;
    logic              rvalid_data;
    logic              inst_gnt;
    logic              dat_gnt;
    logic              rd_grant;
    arb_owner_e        grant_owner;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;

    logic              mem_cs;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DAT_W-1:0]  mem_dat_in;

    // Data wins ties unless fetch has already lost STARVE_MAX times in a row.
    always_comb begin
        inst_gnt = 1'b0;
        dat_gnt  = 1'b0;
        if (!rst && free) begin
            if (bus.inst_req && bus.dat_req) begin
                if (starve_cnt_q == SW'(STARVE_MAX)) begin
                    inst_gnt = 1'b1;
                end else begin
                    dat_gnt = 1'b1;
                end
            end else if (bus.inst_req) begin
                inst_gnt = 1'b1;
            end else if (bus.dat_req) begin
                dat_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.inst_req || inst_gnt) begin
            starve_cnt_d = '0;
        end else if (dat_gnt && (starve_cnt_q != SW'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        mem_cs     = 1'b0;
        mem_wen    = 1'b0;
        mem_addr   = '0;
        mem_dat_in = '0;
        if (inst_gnt) begin
            mem_cs   = 1'b1;
            mem_addr = bus.inst_addr;
        end else if (dat_gnt) begin
            mem_cs     = 1'b1;
            mem_wen    = bus.dat_wen;
            mem_addr   = bus.dat_addr;
            mem_dat_in = bus.dat_wdata;
        end
    end

    // Writes retire in the grant cycle, so only reads reach the tracker.
    assign rd_grant    = inst_gnt || (dat_gnt && !bus.dat_wen);
    assign grant_owner = inst_gnt ? OWN_INST : OWN_DATA;

    mem_arb_lat_tracker #(
        .RD_LAT (RD_LAT)
    ) u_lat_tracker (
        .clk         (clk),
        .rst         (rst),
        .rd_grant    (rd_grant),
        .grant_owner (grant_owner),
        .free        (free),
        .rvalid_inst (rvalid_inst),
        .rvalid_data (rvalid_data)
    );

    assign bus.inst_gnt    = inst_gnt;
    assign bus.dat_gnt     = dat_gnt;
    assign bus.inst_rvalid = rvalid_inst;
    assign bus.dat_rvalid  = rvalid_data;
    assign bus.inst_rdata  = rvalid_inst ? bus.mem_dat_out : '0;
    assign bus.dat_rdata   = rvalid_data ? bus.mem_dat_out : '0;
    assign bus.mem_cs      = mem_cs;
    assign bus.mem_wen     = mem_wen;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_dat_in  = mem_dat_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboarded directed bench over RD_LAT = 1, 2, 3 instances
module tb_mem_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic        inst_req_a    [3];
    logic [31:0] inst_addr_a   [3];
    logic        dat_req_a     [3];
    logic        dat_wen_a     [3];
    logic [31:0] dat_addr_a    [3];
    logic [31:0] dat_wdata_a   [3];
    logic        inst_gnt_a    [3];
    logic        inst_rvalid_a [3];
    logic [31:0] inst_rdata_a  [3];
    logic        dat_gnt_a     [3];
    logic        dat_rvalid_a  [3];
    logic [31:0] dat_rdata_a   [3];
    logic        mem_cs_a      [3];
    logic        mem_wen_a     [3];
    logic [31:0] mem_addr_a    [3];
    logic [31:0] mem_dat_in_a  [3];

    exp_t sbq [3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = k + 1;
        logic [31:0] pipe [4];

        mem_arbiter_if #(.ADDR_W(32), .DAT_W(32)) bus ();

        mem_arbiter #(
            .ADDR_W     (32),
            .DAT_W      (32),
            .RD_LAT     (L),
            .STARVE_MAX (4)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.inst_req  = inst_req_a[k];
        assign bus.inst_addr = inst_addr_a[k];
        assign bus.dat_req   = dat_req_a[k];
        assign bus.dat_wen   = dat_wen_a[k];
        assign bus.dat_addr  = dat_addr_a[k];
        assign bus.dat_wdata = dat_wdata_a[k];

        assign inst_gnt_a[k]    = bus.inst_gnt;
        assign inst_rvalid_a[k] = bus.inst_rvalid;
        assign inst_rdata_a[k]  = bus.inst_rdata;
        assign dat_gnt_a[k]     = bus.dat_gnt;
        assign dat_rvalid_a[k]  = bus.dat_rvalid;
        assign dat_rdata_a[k]   = bus.dat_rdata;
        assign mem_cs_a[k]      = bus.mem_cs;
        assign mem_wen_a[k]     = bus.mem_wen;
        assign mem_addr_a[k]    = bus.mem_addr;
        assign mem_dat_in_a[k]  = bus.mem_dat_in;

        // Memory macro: read data appears L cycles after the chip-select cycle.
        always @(posedge clk) begin
            pipe[0] <= (bus.mem_cs && !bus.mem_wen) ? rd_fn(bus.mem_addr) : 32'hBAD0_0000;
            for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
        end
        assign bus.mem_dat_out = pipe[L-1];

        always @(negedge clk) begin
            exp_t e;
            if (bus.inst_rvalid || bus.dat_rvalid) begin
                if (sbq[k].size() == 0) begin
                    chk($sformatf("unexpected_rvalid_u%0d", k),
                        32'({bus.inst_rvalid, bus.dat_rvalid}), 32'd0);
                end else begin
                    e = sbq[k].pop_front();
                    chk($sformatf("rvalid_port_u%0d", k),
                        32'({bus.inst_rvalid, bus.dat_rvalid}), e.port ? 32'd1 : 32'd2);
                    chk($sformatf("rdata_u%0d", k),
                        e.port ? bus.dat_rdata : bus.inst_rdata, e.data);
                    chk($sformatf("rdata_other_u%0d", k),
                        e.port ? bus.inst_rdata : bus.dat_rdata, 32'd0);
                end
            end else begin
                chk($sformatf("rdata_idle_u%0d", k), bus.inst_rdata | bus.dat_rdata, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push(input int k, input logic port, input logic [31:0] addr);
        exp_t e;
        e.port = port;
        e.data = rd_fn(addr);
        sbq[k].push_back(e);
    endtask

    task automatic chk_quiet(input string tag, input int k);
        chk({tag, "_gnt"}, 32'({inst_gnt_a[k], dat_gnt_a[k]}), 32'd0);
        chk({tag, "_rvalid"}, 32'({inst_rvalid_a[k], dat_rvalid_a[k]}), 32'd0);
        chk({tag, "_cs_wen"}, 32'({mem_cs_a[k], mem_wen_a[k]}), 32'd0);
        chk({tag, "_addr"}, mem_addr_a[k], 32'd0);
        chk({tag, "_din"}, mem_dat_in_a[k], 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inst_req_a[k]  = 1'b0;
            inst_addr_a[k] = '0;
            dat_req_a[k]   = 1'b0;
            dat_wen_a[k]   = 1'b0;
            dat_addr_a[k]  = '0;
            dat_wdata_a[k] = '0;
        end

        // Reset gates requests.
        inst_req_a[0]  = 1'b1;
        inst_addr_a[0] = 32'h44;
        dat_req_a[0]   = 1'b1;
        dat_addr_a[0]  = 32'h48;
        repeat (2) tick();
        sample();
        chk_quiet("reset_gating", 0);
        tick();
        inst_req_a[0] = 1'b0;
        dat_req_a[0]  = 1'b0;
        rst           = 1'b0;
        sample();
        chk_quiet("after_reset", 0);

        // Single fetch, RD_LAT=1.
        tick();
        inst_req_a[0]  = 1'b1;
        inst_addr_a[0] = 32'h40;
        push(0, 1'b0, 32'h40);
        sample();
        chk("fetch_gnt", 32'({inst_gnt_a[0], dat_gnt_a[0]}), 32'd2);
        chk("fetch_cs_wen", 32'({mem_cs_a[0], mem_wen_a[0]}), 32'd2);
        chk("fetch_addr", mem_addr_a[0], 32'h40);
        tick();
        inst_req_a[0] = 1'b0;
        sample();
        chk("fetch_rvalid", 32'(inst_rvalid_a[0]), 32'd1);
        chk("fetch_rdata", inst_rdata_a[0], 32'hDEAD_BEEF);
        chk("fetch_no_cs", 32'(mem_cs_a[0]), 32'd0);

        // Back-to-back fetches, RD_LAT=1.
        for (int i = 0; i < 3; i++) begin
            tick();
            inst_req_a[0]  = 1'b1;
            inst_addr_a[0] = 32'(i * 4);
            push(0, 1'b0, 32'(i * 4));
            sample();
            chk($sformatf("b2b_gnt%0d", i), 32'(inst_gnt_a[0]), 32'd1);
            chk($sformatf("b2b_addr%0d", i), mem_addr_a[0], 32'(i * 4));
            chk($sformatf("b2b_rvalid%0d", i), 32'(inst_rvalid_a[0]), (i == 0) ? 32'd0 : 32'd1);
        end
        tick();
        inst_req_a[0] = 1'b0;
        sample();
        chk("b2b_last_rvalid", 32'(inst_rvalid_a[0]), 32'd1);
        tick();
        sample();
        chk("b2b_drained", 32'(inst_rvalid_a[0]), 32'd0);

        // Conflict: data wins, fetch takes the return cycle.
        tick();
        inst_req_a[0]  = 1'b1;
        inst_addr_a[0] = 32'h300;
        dat_req_a[0]   = 1'b1;
        dat_wen_a[0]   = 1'b0;
        dat_addr_a[0]  = 32'h200;
        push(0, 1'b1, 32'h200);
        sample();
        chk("conflict_gnt", 32'({inst_gnt_a[0], dat_gnt_a[0]}), 32'd1);
        chk("conflict_addr", mem_addr_a[0], 32'h200);
        tick();
        dat_req_a[0] = 1'b0;
        push(0, 1'b0, 32'h300);
        sample();
        chk("conflict_dat_rvalid", 32'(dat_rvalid_a[0]), 32'd1);
        chk("conflict_inst_gnt", 32'({inst_gnt_a[0], dat_gnt_a[0]}), 32'd2);
        chk("conflict_inst_addr", mem_addr_a[0], 32'h300);
        tick();
        inst_req_a[0] = 1'b0;
        sample();
        chk("conflict_inst_rvalid", 32'(inst_rvalid_a[0]), 32'd1);

        // Starvation override after four data writes.
        tick();
        inst_req_a[0]  = 1'b1;
        inst_addr_a[0] = 32'h500;
        dat_req_a[0]   = 1'b1;
        dat_wen_a[0]   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dat_addr_a[0]  = 32'h600 + 32'(i * 4);
            dat_wdata_a[0] = 32'h1111_0000 + 32'(i);
            sample();
            chk($sformatf("starve_dat_gnt%0d", i), 32'({inst_gnt_a[0], dat_gnt_a[0]}), 32'd1);
            chk($sformatf("starve_wr%0d", i), 32'({mem_cs_a[0], mem_wen_a[0]}), 32'd3);
            chk($sformatf("starve_din%0d", i), mem_dat_in_a[0], 32'h1111_0000 + 32'(i));
            tick();
        end
        push(0, 1'b0, 32'h500);
        sample();
        chk("starve_inst_gnt", 32'({inst_gnt_a[0], dat_gnt_a[0]}), 32'd2);
        chk("starve_inst_wen", 32'(mem_wen_a[0]), 32'd0);
        tick();
        inst_addr_a[0] = 32'h504;
        sample();
        chk("starve_cleared", 32'({inst_gnt_a[0], dat_gnt_a[0]}), 32'd1);
        chk("starve_inst_rvalid", 32'(inst_rvalid_a[0]), 32'd1);
        tick();
        inst_req_a[0] = 1'b0;
        dat_req_a[0]  = 1'b0;
        dat_wen_a[0]  = 1'b0;
        sample();

        // Write held off by a pending read, RD_LAT=3.
        tick();
        inst_req_a[2]  = 1'b1;
        inst_addr_a[2] = 32'h700;
        push(2, 1'b0, 32'h700);
        sample();
        chk("wr_during_rd_inst_gnt", 32'(inst_gnt_a[2]), 32'd1);
        tick();
        inst_req_a[2]  = 1'b0;
        dat_req_a[2]   = 1'b1;
        dat_wen_a[2]   = 1'b1;
        dat_addr_a[2]  = 32'h704;
        dat_wdata_a[2] = 32'hCAFE_F00D;
        sample();
        chk("wr_hold_t1", 32'({dat_gnt_a[2], mem_cs_a[2]}), 32'd0);
        tick();
        sample();
        chk("wr_hold_t2", 32'({dat_gnt_a[2], mem_cs_a[2]}), 32'd0);
        tick();
        sample();
        chk("wr_gnt_t3", 32'(dat_gnt_a[2]), 32'd1);
        chk("wr_t3_inst_rvalid", 32'(inst_rvalid_a[2]), 32'd1);
        chk("wr_t3_wen", 32'(mem_wen_a[2]), 32'd1);
        chk("wr_t3_addr", mem_addr_a[2], 32'h704);
        chk("wr_t3_din", mem_dat_in_a[2], 32'hCAFE_F00D);
        chk("wr_t3_no_dat_rvalid", 32'(dat_rvalid_a[2]), 32'd0);
        tick();
        dat_req_a[2] = 1'b0;
        dat_wen_a[2] = 1'b0;
        sample();
        chk("wr_after_rvalid", 32'({inst_rvalid_a[2], dat_rvalid_a[2]}), 32'd0);

        // Reset in the middle of a read, RD_LAT=2.
        tick();
        inst_req_a[1]  = 1'b1;
        inst_addr_a[1] = 32'h100;
        push(1, 1'b0, 32'h100);
        sample();
        chk("rst_rd_gnt", 32'(inst_gnt_a[1]), 32'd1);
        tick();
        inst_req_a[1]  = 1'b0;
        dat_req_a[1]   = 1'b1;
        dat_wen_a[1]   = 1'b1;
        dat_addr_a[1]  = 32'h104;
        dat_wdata_a[1] = 32'h0BAD_CAFE;
        rst            = 1'b1;
        sbq[1].delete();
        #1;
        chk_quiet("rst_mid_read", 1);
        repeat (2) tick();
        rst = 1'b0;
        sample();
        chk("rst_first_gnt", 32'(dat_gnt_a[1]), 32'd1);
        chk("rst_first_din", mem_dat_in_a[1], 32'h0BAD_CAFE);
        tick();
        dat_req_a[1] = 1'b0;
        dat_wen_a[1] = 1'b0;
        repeat (4) tick();
        sample();

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sb_empty_u%0d", k), 32'(sbq[k].size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares a single-port main memory between the fetch-stage instruction port (read-only) and the memory-access-stage data port (read/write), so the core can run from one unified memory. Sits between the CPU top and the memory macro, and presents the same cs/wen/addr/dat_in/dat_out memory interface the core already uses. Arbitration is fixed-priority to data with an anti-starvation override for fetch. Only one access is outstanding at a time, and read data returns after a fixed memory latency.

Parameters:
ADDR_W, 32, address width
DAT_W, 32, data width
RD_LAT, 1, memory read latency in cycles; legal range 1..4
STARVE_MAX, 4, maximum consecutive data grants while fetch is waiting; legal range >=1

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
inst_req  in  1  fetch read request
inst_addr  in  ADDR_W  fetch address
inst_gnt  out  1  fetch request accepted this cycle
inst_rvalid  out  1  fetch read data valid
inst_rdata  out  DAT_W  fetch read data
dat_req  in  1  data request
dat_wen  in  1  1 = write, 0 = read
dat_addr  in  ADDR_W  data address
dat_wdata  in  DAT_W  write data
dat_gnt  out  1  data request accepted this cycle
dat_rvalid  out  1  data read data valid
dat_rdata  out  DAT_W  data read data
mem_cs  out  1  memory chip-select
mem_wen  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_dat_in  out  DAT_W  memory write data (from memory POV)
mem_dat_out  in  DAT_W  memory read data (from memory POV)

Behaviour:
- State: FSM {IDLE, RD_WAIT}; lat_cnt (width of RD_LAT); owner {INST, DATA}; starve_cnt (clog2(STARVE_MAX+1) bits).
- Reset (async, immediate): state=IDLE, lat_cnt=0, owner=INST, starve_cnt=0. All *_gnt, *_rvalid and mem_cs are 0. mem_wen, mem_addr and mem_dat_in are 0.
- The arbiter is free when state==IDLE, or when state==RD_WAIT and lat_cnt==1 (the return cycle).
- Grants are combinational in the request cycle and at most one per cycle. Grant rules when the arbiter is free:
  - Only one requester active: that requester is granted.
  - Both active and starve_cnt==STARVE_MAX: inst is granted.
  - Both active otherwise: dat is granted.
- Requester rule: keep req, addr, wen and wdata stable until gnt. The arbiter does not latch ungranted requests.
- Memory drive: in a grant cycle, mem_cs=1 and mem_addr/mem_wen/mem_dat_in come from the winner. For inst, mem_wen=0 and mem_dat_in=0. With no grant, mem_cs=0 and the other memory outputs are 0.
- A write grant completes in the grant cycle: no rvalid is produced, the state is unchanged, and IDLE stays IDLE.
- A read grant in cycle t: the next state is RD_WAIT, lat_cnt=RD_LAT, and owner is set to the winner.
- RD_WAIT:
  - lat_cnt decrements each cycle.
  - When lat_cnt==1 (cycle t+RD_LAT), the owner's rvalid=1 and its rdata=mem_dat_out.
  - In that same cycle a new grant is allowed. A new read reloads the counter; otherwise the FSM goes to IDLE.
- Throughput: with RD_LAT=1, one read per cycle back-to-back.
- rdata on the non-owning port, or when rvalid=0, is 0.
- No grant is issued while lat_cnt>1. This applies to writes as well.
- starve_cnt:
  - +1 on each dat grant while inst_req=1.
  - Cleared on an inst grant, or on any cycle with inst_req=0.
  - Saturates at STARVE_MAX.
- Reset during RD_WAIT discards the pending read: no rvalid after reset is released.

Decomposition:
- Shared package etcpu_pkg holds:
  - typedef arb_state_e {IDLE, RD_WAIT}
  - typedef arb_owner_e {OWN_INST, OWN_DATA}
  - localparam default widths (ADDR_W and DAT_W of 32)
- Sub-module mem_arb_lat_tracker: holds the FSM, lat_cnt and owner. Inputs are rd_grant and grant_owner; outputs are free, rvalid_inst and rvalid_data.
- The top level keeps the priority/starvation logic and the memory muxing.

Test Plan:
- Reset: assert rst mid-read (RD_LAT=2, inst read at 0x100 granted) -> all outputs 0 immediately; no inst_rvalid after release; first request after reset is granted the same cycle.
- Single fetch, RD_LAT=1: inst_req with addr 0x40, memory returns 0xDEADBEEF -> inst_gnt and mem_cs in cycle t with mem_addr=0x40, mem_wen=0; inst_rvalid=1 and inst_rdata=0xDEADBEEF at t+1.
- Back-to-back reads, RD_LAT=1: inst_req held with addresses 0x0, 0x4, 0x8 -> a grant every cycle; three consecutive inst_rvalid pulses in order.
- Conflict: inst_req and dat_req (read 0x200) both high in IDLE -> dat_gnt=1, inst_gnt=0; inst is granted in the dat rvalid cycle if dat_req drops.
- Starvation, STARVE_MAX=4: inst_req held while dat_req issues writes every cycle -> dat_gnt on 4 cycles, then inst_gnt on the 5th cycle with dat_gnt=0, then starve_cnt=0.
- Write during a read, RD_LAT=3: inst read at t, dat write requested at t+1 -> dat_gnt withheld at t+1 and t+2; granted at t+3 together with inst_rvalid, with mem_wen=1 and mem_dat_in equal to the write data; no dat_rvalid.
